i_cache_2way: RTL

I_CACHE_2WAY -- requirements
Module: i_cache_2way

---
 rtl/i_cache_2way.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/i_cache_2way.sv
// i_cache_2way: two-way set-associative, read-only instruction cache.
// Each set holds two ways (valid, tag, block) and one LRU bit naming the next
// victim. A whole-cache flush clears the valid and LRU bits. Hit and miss
// counters saturate. All state updates on the falling edge of CLK; RESET is
// asynchronous and active-high.
//
// Handshakes:
//   CPU side    - READ requests the word at ADDR. While BUSYWAIT is high the CPU
//                 holds ADDR and READ. INSTRUCTION is valid in any IDLE cycle
//                 where BUSYWAIT is low and READ is high.
//   Memory side - MEM_READ stays high with a constant MEM_ADDR for the whole
//                 memory-read state. The first falling edge that sees
//                 MEM_BUSYWAIT low takes MEM_READDATA as the complete block.
//                 That edge also ends the request.
// DBG_STATE exposes the controller state (0 idle, 1 mem read, 2 allocate).
module i_cache_2way #(
   parameter int SETS        = 8,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                              CLK,
   input  logic                              RESET,
   input  logic [31:0]                       ADDR,
   input  logic                              READ,
   input  logic                              FLUSH,
   output logic [31:0]                       INSTRUCTION,
   output logic                              BUSYWAIT,
   output logic                              MEM_READ,
   output logic [29-$clog2(BLOCK_WORDS):0]   MEM_ADDR,
   input  logic                              MEM_BUSYWAIT,
   input  logic [32*BLOCK_WORDS-1:0]         MEM_READDATA,
   output logic [31:0]                       HIT_COUNT,
   output logic [31:0]                       MISS_COUNT,
   output logic [1:0]                        DBG_STATE
);

   localparam int OFF_W   = $clog2(BLOCK_WORDS);
   localparam int IDX_W   = $clog2(SETS);
   localparam int TAG_W   = 30 - OFF_W - IDX_W;
   localparam int BADDR_W = 30 - OFF_W;
   localparam int BLK_W   = 32 * BLOCK_WORDS;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_READ = 2'd1,
      ST_ALLOCATE = 2'd2
   } state_t;

   state_t               state_q, state_d;

   // Address fields of the current fetch
   logic [OFF_W-1:0]     addr_off;
   logic [IDX_W-1:0]     addr_idx;
   logic [TAG_W-1:0]     addr_tag;
   logic [BADDR_W-1:0]   addr_baddr;
   logic                 unused_addr_bits;

   // Per-set status bits (reset) and per-way storage (not reset)
   logic [SETS-1:0]      valid0_q, valid1_q;
   logic [SETS-1:0]      lru_q;          // 0: way 0 is the victim, 1: way 1
   logic [TAG_W-1:0]     tag0_q  [SETS];
   logic [TAG_W-1:0]     tag1_q  [SETS];
   logic [BLK_W-1:0]     data0_q [SETS];
   logic [BLK_W-1:0]     data1_q [SETS];

   // Miss context captured when a miss starts
   logic [BADDR_W-1:0]   baddr_q, baddr_d;
   logic                 victim_q, victim_d;

   logic [31:0]          hit_cnt_q, hit_cnt_d;
   logic [31:0]          miss_cnt_q, miss_cnt_d;

   // Lookup and control strobes
   logic                 hit0, hit1, hit;
   logic                 victim_way;
   logic [BLK_W-1:0]     sel_block;
   logic [IDX_W-1:0]     fill_idx;
   logic [TAG_W-1:0]     fill_tag;
   logic                 do_hit, do_miss, do_fill, do_flush;

   assign addr_off         = ADDR[2+OFF_W-1:2];
   assign addr_idx         = ADDR[2+OFF_W+IDX_W-1:2+OFF_W];
   assign addr_tag         = ADDR[31:32-TAG_W];
   assign addr_baddr       = ADDR[31:2+OFF_W];
   assign unused_addr_bits = ^ADDR[1:0];

   // The latched block address already holds the fill index and tag.
   assign fill_idx = baddr_q[IDX_W-1:0];
   assign fill_tag = baddr_q[BADDR_W-1:IDX_W];

   // Tag compare of both ways, word select from the hitting way, victim choice
   always_comb begin
      hit0 = valid0_q[addr_idx] && (tag0_q[addr_idx] == addr_tag);
      hit1 = valid1_q[addr_idx] && (tag1_q[addr_idx] == addr_tag);
      hit  = hit0 || hit1;
      // Ways never both match, so way 1 only needs to win when it hits.
      sel_block   = hit1 ? data1_q[addr_idx] : data0_q[addr_idx];
      INSTRUCTION = sel_block[{addr_off, 5'b00000} +: 32];
      // Fill empty ways in order before evicting by LRU.
      if (!valid0_q[addr_idx]) begin
         victim_way = 1'b0;
      end else if (!valid1_q[addr_idx]) begin
         victim_way = 1'b1;
      end else begin
         victim_way = lru_q[addr_idx];
      end
   end

   // Controller next state, CPU/memory handshake outputs and update strobes
   always_comb begin
      state_d  = state_q;
      baddr_d  = baddr_q;
      victim_d = victim_q;
      BUSYWAIT = 1'b0;
      MEM_READ = 1'b0;
      do_hit   = 1'b0;
      do_miss  = 1'b0;
      do_fill  = 1'b0;
      do_flush = 1'b0;
      case (state_q)
         ST_IDLE: begin
            BUSYWAIT = READ && !hit;
            if (FLUSH) begin
               // Flush has priority: no lookup bookkeeping, no miss.
               do_flush = 1'b1;
            end else if (READ && hit) begin
               do_hit = 1'b1;
            end else if (READ) begin
               do_miss  = 1'b1;
               baddr_d  = addr_baddr;
               victim_d = victim_way;
               state_d  = ST_MEM_READ;
            end
         end
         ST_MEM_READ: begin
            BUSYWAIT = 1'b1;
            MEM_READ = 1'b1;
            if (!MEM_BUSYWAIT) begin
               do_fill = 1'b1;
               state_d = ST_ALLOCATE;
            end
         end
         ST_ALLOCATE: begin
            // One cycle for the refilled block to become visible to the lookup.
            BUSYWAIT = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Saturating performance counters
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (do_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (do_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   // Controller state, miss context, status bits and counters
   always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         baddr_q    <= '0;
         victim_q   <= 1'b0;
         valid0_q   <= '0;
         valid1_q   <= '0;
         lru_q      <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         baddr_q    <= baddr_d;
         victim_q   <= victim_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         if (do_flush) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
         end else begin
            if (do_hit) begin
               // A hit in way 0 makes way 1 the victim, and vice versa.
               lru_q[addr_idx] <= hit0;
            end
            if (do_fill) begin
               if (victim_q) begin
                  valid1_q[fill_idx] <= 1'b1;
               end else begin
                  valid0_q[fill_idx] <= 1'b1;
               end
               lru_q[fill_idx] <= ~victim_q;
            end
         end
      end
   end

   // Tag and block storage, written only by a refill
   always_ff @(negedge CLK) begin
      if (do_fill) begin
         if (victim_q) begin
            tag1_q[fill_idx]  <= fill_tag;
            data1_q[fill_idx] <= MEM_READDATA;
         end else begin
            tag0_q[fill_idx]  <= fill_tag;
            data0_q[fill_idx] <= MEM_READDATA;
         end
      end
   end

   assign MEM_ADDR   = baddr_q;
   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;
   assign DBG_STATE  = state_q;

endmodule
